// File: rtl/prog_seq_ctr_pkg.sv
// prog_seq_ctr_pkg: shared state/next-PC encodings and entry-table lookup for prog_seq_ctr
package prog_seq_ctr_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} psc_state_t;
  typedef enum logic [2:0] {HOLD, INC, JMP, BUP, BDN, CALL, RET} psc_nextpc_t;
  localparam int unsigned PSC_TBL_MAX  = 1024;
  localparam int unsigned PSC_ADDR_MAX = 32;
  // program k (1-based) lives at bits [k*w-1:(k-1)*w]; caller truncates to its PC width
  function automatic logic [PSC_ADDR_MAX-1:0] entry_addr(input logic [PSC_TBL_MAX-1:0] tbl,
                                                         input int unsigned w, input int unsigned idx);
    return PSC_ADDR_MAX'(tbl >> (w * (idx - 1)));
  endfunction
endpackage

// File: rtl/prog_seq_ctr_start_edge_det.sv
// prog_seq_ctr_start_edge_det: registers Start and flags its rising/falling edges
module prog_seq_ctr_start_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic rise,
  output logic fall
);
  logic start_q;
  // previous-cycle copy of the strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start;
  assign rise = start & ~start_q;
  assign fall = ~start & start_q;
endmodule

// File: rtl/prog_seq_ctr.sv
// prog_seq_ctr: program counter with multi-program launch sequencer; define PSC_CALL_EN for Call/Ret with a link register
module prog_seq_ctr
  import prog_seq_ctr_pkg::*;
#(
  parameter int L         = 10,
  parameter int OFF_W     = 8,
  parameter int NUM_PROGS = 3,
  parameter logic [NUM_PROGS*L-1:0] ENTRY_ADDRS = {10'd639, 10'd190, 10'd0}
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Start,
  input  logic                         Halt,
  input  logic                         Stall,
  input  logic                         BranchUp,
  input  logic                         BranchDown,
  input  logic                         Jump,
  input  logic [OFF_W-1:0]             PCTarget,
  input  logic [L-1:0]                 JumpAddr,
`ifdef PSC_CALL_EN
  input  logic                         Call,
  input  logic                         Ret,
`endif
  output logic [L-1:0]                 ProgCtr,
  output logic [$clog2(NUM_PROGS+1)-1:0] ProgIdx,
  output logic                         Running,
  output logic                         Done,
  output logic                         Err
);
  localparam int IW = $clog2(NUM_PROGS + 1);
  localparam int PW = $clog2(NUM_PROGS + 2);
  psc_state_t  state_q, state_d;
  psc_nextpc_t sel;
  logic [L-1:0]  pc_q, pc_d, off;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          err_q, err_d, rise, fall, launch, launch_ok, in_run, acting, conflict;
`ifdef PSC_CALL_EN
  logic [L-1:0]  link_q, link_d;
`endif
  prog_seq_ctr_start_edge_det u_edge (
    .clk   (Clk),
    .rst_n (Reset_n),
    .start (Start),
    .rise  (rise),
    .fall  (fall)
  );
  assign off       = L'(PCTarget);
  assign launch    = fall && state_q != LOAD;
  assign launch_ok = 32'(pend_q) <= NUM_PROGS;
  assign in_run    = state_q == RUN && !fall;
  assign acting    = in_run && !Halt && !Stall;
  // state and datapath registers
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
`ifdef PSC_CALL_EN
      link_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
`ifdef PSC_CALL_EN
      link_q  <= link_d;
`endif
    end
  // next state: a launch preempts everything, an out-of-range launch parks in HALTED
  always_comb begin
    state_d = launch ? (launch_ok ? LOAD : HALTED) :
              (state_q == LOAD) ? RUN :
              (state_q == RUN && Halt && !Stall) ? HALTED : state_q;
  end
  // next-PC source, lowest priority first so later lines override
  always_comb begin
    sel = INC;
    if (BranchDown) sel = BDN;
    if (BranchUp) sel = BUP;
    if (Jump) sel = JMP;
`ifdef PSC_CALL_EN
    if (Ret) sel = RET;
    if (Call) sel = CALL;
`endif
    if (!acting) sel = HOLD;
  end
  // PC mux, launch bookkeeping and sticky error
  always_comb begin
    conflict = acting && ((Jump && BranchUp) || (Jump && BranchDown) || (BranchUp && BranchDown));
`ifdef PSC_CALL_EN
    conflict = conflict || (acting && Call && Ret);
    link_d   = (state_q == LOAD) ? '0 : (sel == CALL) ? pc_q + L'(1) : link_q;
`endif
    pc_d   = (state_q == LOAD) ? L'(entry_addr(PSC_TBL_MAX'(ENTRY_ADDRS), L, 32'(pend_q))) :
             (sel == INC) ? pc_q + L'(1) :
             (sel == JMP) ? JumpAddr :
             (sel == BUP) ? pc_q - off :
             (sel == BDN) ? pc_q + off :
`ifdef PSC_CALL_EN
             (sel == CALL) ? JumpAddr :
             (sel == RET) ? link_q :
`endif
             pc_q;
    pend_d = rise ? PW'(idx_q) + PW'(1) : pend_q;
    idx_d  = (state_q == LOAD) ? IW'(pend_q) : idx_q;
    err_d  = err_q || conflict || (launch && !launch_ok);
  end
  // outputs are decodes of registered state only
  always_comb begin
    ProgCtr = pc_q;
    ProgIdx = idx_q;
    Running = state_q == RUN;
    Done    = state_q == HALTED;
    Err     = err_q;
  end
endmodule

// File: tb/tb_prog_seq_ctr.sv
// tb_prog_seq_ctr: directed self-checking bench for prog_seq_ctr (Call/Ret scenario when PSC_CALL_EN is defined)
module tb_prog_seq_ctr;
  logic       Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0, Halt = 1'b0, Stall = 1'b0;
  logic       BranchUp = 1'b0, BranchDown = 1'b0, Jump = 1'b0;
  logic [7:0] PCTarget = '0;
  logic [9:0] JumpAddr = '0;
`ifdef PSC_CALL_EN
  logic       Call = 1'b0, Ret = 1'b0;
`endif
  logic [9:0] ProgCtr;
  logic [1:0] ProgIdx;
  logic       Running, Done, Err;
  int errors = 0, checks = 0;

  prog_seq_ctr dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt), .Stall(Stall),
    .BranchUp(BranchUp), .BranchDown(BranchDown), .Jump(Jump),
    .PCTarget(PCTarget), .JumpAddr(JumpAddr),
`ifdef PSC_CALL_EN
    .Call(Call), .Ret(Ret),
`endif
    .ProgCtr(ProgCtr), .ProgIdx(ProgIdx), .Running(Running), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic launch;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    #3;
    checks++; if (ProgCtr !== 10'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", ProgCtr); end
    checks++; if ({ProgIdx, Running, Done, Err} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {ProgIdx, Running, Done, Err}); end
    @(negedge Clk);
    Reset_n = 1'b1;
    tick(3);
    checks++; if (ProgCtr !== 10'd0 || Running !== 1'b0) begin errors++; $display("FAIL idle_hold got pc=%0d run=%b exp pc=0 run=0", ProgCtr, Running); end
  endtask

  task automatic test_launch;
    launch();
    checks++; if (ProgCtr !== 10'd0 || ProgIdx !== 2'd1 || Running !== 1'b1) begin errors++; $display("FAIL launch1 got pc=%0d idx=%0d run=%b exp pc=0 idx=1 run=1", ProgCtr, ProgIdx, Running); end
    tick(5);
    checks++; if (ProgCtr !== 10'd5) begin errors++; $display("FAIL inc5 got=%0d exp=5", ProgCtr); end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    checks++; if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 10'd5) begin errors++; $display("FAIL halt got done=%b run=%b pc=%0d exp done=1 run=0 pc=5", Done, Running, ProgCtr); end
    Jump = 1'b1; JumpAddr = 10'd77;
    tick(2);
    Jump = 1'b0;
    checks++; if (ProgCtr !== 10'd5 || Done !== 1'b1) begin errors++; $display("FAIL halted_hold got pc=%0d done=%b exp pc=5 done=1", ProgCtr, Done); end
  endtask

  task automatic test_branch;
    launch();
    checks++; if (ProgCtr !== 10'd190 || ProgIdx !== 2'd2 || Running !== 1'b1) begin errors++; $display("FAIL launch2 got pc=%0d idx=%0d run=%b exp pc=190 idx=2 run=1", ProgCtr, ProgIdx, Running); end
    BranchUp = 1'b1; PCTarget = 8'd200;
    tick();
    BranchUp = 1'b0;
    checks++; if (ProgCtr !== 10'd1014) begin errors++; $display("FAIL bup_wrap got=%0d exp=1014", ProgCtr); end
    BranchDown = 1'b1; PCTarget = 8'd10;
    tick();
    BranchDown = 1'b0;
    checks++; if (ProgCtr !== 10'd0) begin errors++; $display("FAIL bdn_wrap got=%0d exp=0", ProgCtr); end
  endtask

  task automatic test_conflict;
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL err_pre got=%b exp=0", Err); end
    Jump = 1'b1; BranchDown = 1'b1; JumpAddr = 10'd300; PCTarget = 8'd5;
    tick();
    BranchDown = 1'b0;
    checks++; if (ProgCtr !== 10'd300 || Err !== 1'b1) begin errors++; $display("FAIL jump_conflict got pc=%0d err=%b exp pc=300 err=1", ProgCtr, Err); end
    Stall = 1'b1; JumpAddr = 10'd500;
    tick();
    Stall = 1'b0; Jump = 1'b0;
    checks++; if (ProgCtr !== 10'd300 || Err !== 1'b1) begin errors++; $display("FAIL stall_jump got pc=%0d err=%b exp pc=300 err=1", ProgCtr, Err); end
  endtask

`ifdef PSC_CALL_EN
  task automatic test_call;
    Jump = 1'b1; JumpAddr = 10'd200;
    tick();
    Jump = 1'b0;
    Call = 1'b1; JumpAddr = 10'd400;
    tick();
    Call = 1'b0;
    checks++; if (ProgCtr !== 10'd400) begin errors++; $display("FAIL call got=%0d exp=400", ProgCtr); end
    tick(3);
    checks++; if (ProgCtr !== 10'd403) begin errors++; $display("FAIL call_inc got=%0d exp=403", ProgCtr); end
    Ret = 1'b1;
    tick();
    Ret = 1'b0;
    checks++; if (ProgCtr !== 10'd201) begin errors++; $display("FAIL ret got=%0d exp=201", ProgCtr); end
  endtask
`endif

  task automatic test_reset_mid_run;
    Jump = 1'b1; JumpAddr = 10'd57;
    tick();
    Jump = 1'b0;
    checks++; if (ProgCtr !== 10'd57 || Running !== 1'b1) begin errors++; $display("FAIL pre_reset got pc=%0d run=%b exp pc=57 run=1", ProgCtr, Running); end
    test_reset();
  endtask

  task automatic test_back_to_back;
    launch();
    launch();
    launch();
    checks++; if (ProgCtr !== 10'd639 || ProgIdx !== 2'd3 || Err !== 1'b0) begin errors++; $display("FAIL launch3 got pc=%0d idx=%0d err=%b exp pc=639 idx=3 err=0", ProgCtr, ProgIdx, Err); end
    tick(2);
    Start = 1'b1;
    tick();
    checks++; if (ProgCtr !== 10'd642 || Running !== 1'b1) begin errors++; $display("FAIL pre_launch4 got pc=%0d run=%b exp pc=642 run=1", ProgCtr, Running); end
    Start = 1'b0;
    tick();
    checks++; if (Err !== 1'b1 || Done !== 1'b1 || Running !== 1'b0) begin errors++; $display("FAIL launch4 got err=%b done=%b run=%b exp err=1 done=1 run=0", Err, Done, Running); end
    tick(2);
    checks++; if (ProgCtr !== 10'd642 || ProgIdx !== 2'd3) begin errors++; $display("FAIL launch4_hold got pc=%0d idx=%0d exp pc=642 idx=3", ProgCtr, ProgIdx); end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_branch();
    test_conflict();
`ifdef PSC_CALL_EN
    test_call();
`endif
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
